conv_sequencer: RTL

Parametrised successor to the convolutor control FSM. It sequences a complete 1-D linear convolution z[k] = Σ x[i]·y[k−i] for runtime sizes. It owns address generation, a pipelined multiply-accumulate with configurable memory read latency, result write-out and the start/busy/done handshake. It sits between the SoC register interface and the X/Y source memories and Z result memory.

---
 rtl/conv_sequencer.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/conv_sequencer.sv
// conv_sequencer: sequences a full 1-D linear convolution z[k] = sum x[i]*y[k-i]
// for runtime sizes Nx, Ny. Generates X/Y read addresses, accumulates products
// through a read pipeline of MEM_LAT cycles and writes each z[k] to Z memory.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start_i               level start request, accepted only when idle
//   size_x_i, size_y_i    Nx, Ny, sampled when start_i is accepted
//   x_addr_o, y_addr_o    X/Y read addresses, qualified by x_rd_o
//   x_rd_o                read strobe for both X and Y memories
//   x_data_i, y_data_i    read data, valid MEM_LAT cycles after the strobe
//   z_addr_o, z_data_o    result index k and value
//   z_write_o             one-cycle Z write strobe
//   busy_o, done_o        run in progress / run finished
//   err_o                 zero size requested, sticky until the next accepted start
module conv_sequencer #(
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ACC_W   = 2 * DATA_W + ADDR_W,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] size_x_i,
    input  logic [ADDR_W-1:0] size_y_i,
    output logic [ADDR_W-1:0] x_addr_o,
    output logic [ADDR_W-1:0] y_addr_o,
    output logic              x_rd_o,
    input  logic [DATA_W-1:0] x_data_i,
    input  logic [DATA_W-1:0] y_data_i,
    output logic [ADDR_W:0]   z_addr_o,
    output logic [ACC_W-1:0]  z_data_o,
    output logic              z_write_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam int unsigned KW = ADDR_W + 1;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StIssue,
        StDrain,
        StWrite,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   nx_q, nx_d;
    logic [ADDR_W-1:0]   ny_q, ny_d;
    logic [KW-1:0]       nz_q, nz_d;
    logic [KW-1:0]       k_q, k_d;
    logic [ADDR_W-1:0]   i_q, i_d;
    logic [2:0]          dcnt_q, dcnt_d;
    logic [MEM_LAT-1:0]  vld_q, vld_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic                err_q, err_d;

    logic [KW-1:0]       nx_w, ny_w, hi_k, k_inc;
    logic [2*DATA_W-1:0] prod;

    assign nx_w  = {1'b0, nx_q};
    assign ny_w  = {1'b0, ny_q};
    assign k_inc = k_q + KW'(1);
    // Last x index contributing to window k.
    assign hi_k  = (k_q < nx_w) ? k_q : nx_w - KW'(1);
    assign prod  = (2 * DATA_W)'(x_data_i) * (2 * DATA_W)'(y_data_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            nx_q    <= '0;
            ny_q    <= '0;
            nz_q    <= '0;
            k_q     <= '0;
            i_q     <= '0;
            dcnt_q  <= '0;
            vld_q   <= '0;
            acc_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            nx_q    <= nx_d;
            ny_q    <= ny_d;
            nz_q    <= nz_d;
            k_q     <= k_d;
            i_q     <= i_d;
            dcnt_q  <= dcnt_d;
            vld_q   <= vld_d;
            acc_q   <= acc_d;
            err_q   <= err_d;
        end
    end

    // Valid pipeline mirrors the memory read latency; the oldest stage marks
    // the cycle in which x_data_i/y_data_i belong to an issued read.
    always_comb begin
        vld_d    = '0;
        vld_d[0] = x_rd_o;
        for (int unsigned j = 1; j < MEM_LAT; j++) begin
            vld_d[j] = vld_q[j-1];
        end
    end

    always_comb begin
        state_d = state_q;
        nx_d    = nx_q;
        ny_d    = ny_q;
        nz_d    = nz_q;
        k_d     = k_q;
        i_d     = i_q;
        dcnt_d  = dcnt_q;
        acc_d   = acc_q;
        err_d   = err_q;

        if (vld_q[MEM_LAT-1]) begin
            acc_d = acc_q + ACC_W'(prod);
        end

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StLoad;
                    nx_d    = size_x_i;
                    ny_d    = size_y_i;
                    k_d     = '0;
                    err_d   = 1'b0;
                end
            end
            StLoad: begin
                if (nx_q == '0 || ny_q == '0) begin
                    state_d = StDone;
                    err_d   = 1'b1;
                end else begin
                    nz_d    = nx_w + ny_w - KW'(1);
                    i_d     = '0;
                    acc_d   = '0;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if ({1'b0, i_q} == hi_k) begin
                    state_d = StDrain;
                    dcnt_d  = '0;
                end else begin
                    i_d = i_q + ADDR_W'(1);
                end
            end
            StDrain: begin
                if (dcnt_q == 3'(MEM_LAT - 1)) begin
                    state_d = StWrite;
                end else begin
                    dcnt_d = dcnt_q + 3'd1;
                end
            end
            StWrite: begin
                if (k_q == nz_q - KW'(1)) begin
                    state_d = StDone;
                end else begin
                    k_d     = k_inc;
                    // First x index of the next window: max(0, k+1-Ny+1).
                    i_d     = ADDR_W'((k_inc >= ny_w) ? k_inc - ny_w + KW'(1) : KW'(0));
                    acc_d   = '0;
                    state_d = StIssue;
                end
            end
            StDone: begin
                if (!start_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        x_rd_o    = (state_q == StIssue);
        x_addr_o  = x_rd_o ? i_q : '0;
        y_addr_o  = x_rd_o ? ADDR_W'(k_q - {1'b0, i_q}) : '0;
        z_write_o = (state_q == StWrite);
        z_addr_o  = z_write_o ? k_q : '0;
        z_data_o  = z_write_o ? acc_q : '0;
        busy_o    = (state_q == StLoad) || (state_q == StIssue) ||
                    (state_q == StDrain) || (state_q == StWrite);
        done_o    = (state_q == StDone);
        err_o     = err_q;
    end

endmodule
